chaos_boot_harness: RTL and testbench



---
 rtl/chaos_boot_pkg.sv | 25 ++
 rtl/boot_uart_tx.sv | 50 +++++
 rtl/chaos_boot_harness.sv | 184 ++++++++++++++++++
 tb/tb_chaos_boot_harness.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/chaos_boot_pkg.sv
// Shared constants and types for the chaos-automaton boot harness.
package chaos_boot_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StExec,
    StWait,
    StUart,
    StHalt
  } boot_state_e;

  localparam logic [3:0] OP_HALT   = 4'h0;
  localparam logic [3:0] OP_SET_IO = 4'h1;
  localparam logic [3:0] OP_UART   = 4'h2;
  localparam logic [3:0] OP_WAIT   = 4'h3;

  localparam logic [7:0] FLASH_READ_CMD = 8'h03;

  localparam int unsigned CHECK_LSB = 16;
  localparam int unsigned UART_PAD  = 6;

endpackage

// File: rtl/boot_uart_tx.sv
// 8N1 transmitter: start pulse loads a 10-bit frame, busy stays high until the stop bit ends.
module boot_uart_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(BAUD_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);

  logic            busy_q;
  logic [9:0]      shreg_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= 1'b0;
      shreg_q <= '1;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q  <= 1'b1;
        shreg_q <= {1'b1, data, 1'b0};
        cnt_q   <= '0;
        idx_q   <= '0;
      end
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      if (idx_q == 4'd9) begin
        busy_q <= 1'b0;
      end else begin
        shreg_q <= {1'b1, shreg_q[9:1]};
        idx_q   <= idx_q + 4'd1;
      end
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign busy = busy_q;
  assign tx   = busy_q ? shreg_q[0] : 1'b1;

endmodule

// File: rtl/chaos_boot_harness.sv
// Boot harness: fetches command words from SPI flash and drives checkbits and a UART on the pads.
module chaos_boot_harness
  import chaos_boot_pkg::*;
#(
  parameter int unsigned FLASH_DIV  = 1,
  parameter int unsigned BAUD_DIV   = 434,
  parameter logic [23:0] START_ADDR = 24'h000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1,
  input  logic [37:0] mprj_io_in,
  output logic [37:0] mprj_io_out,
  output logic [37:0] mprj_io_oeb,
  output logic        gpio
);

  localparam int unsigned DivW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(FLASH_DIV - 1);

  boot_state_e     state_q, state_d;
  logic            csb_q, csb_d;
  logic            sclk_q, sclk_d;
  logic            io0_q, io0_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      bit_q, bit_d;
  logic [31:0]     tx_sh_q, tx_sh_d;
  logic [31:0]     rx_q, rx_d;
  logic [23:0]     addr_q, addr_d;
  logic [23:0]     wait_q, wait_d;
  logic [15:0]     check_q, check_d;
  logic            uart_start, uart_busy, uart_tx;
  logic [31:0]     cmd_word;
  logic            unused_pads;

  assign unused_pads = ^mprj_io_in;
  assign cmd_word    = {FLASH_READ_CMD, addr_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      io0_q   <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      tx_sh_q <= '0;
      rx_q    <= '0;
      addr_q  <= START_ADDR;
      wait_q  <= '0;
      check_q <= '0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      io0_q   <= io0_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_sh_q <= tx_sh_d;
      rx_q    <= rx_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      check_q <= check_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    csb_d      = csb_q;
    sclk_d     = sclk_q;
    io0_d      = io0_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_sh_d    = tx_sh_q;
    rx_d       = rx_q;
    addr_d     = addr_q;
    wait_d     = wait_q;
    check_d    = check_q;
    uart_start = 1'b0;
    case (state_q)
      StIdle: state_d = StCmd;
      StCmd, StAddr, StData: begin
        if (csb_q) begin
          // First cycle of a transaction: select the flash and present the first MOSI bit.
          csb_d   = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          io0_d   = cmd_word[31];
          tx_sh_d = {cmd_word[30:0], 1'b0};
        end else if (div_q == DivLast) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[30:0], flash_io1};
            if (bit_q == 6'd63) begin
              state_d = StExec;
              addr_d  = addr_q + 24'd4;
            end
          end else begin
            sclk_d  = 1'b0;
            io0_d   = tx_sh_q[31];
            tx_sh_d = {tx_sh_q[30:0], 1'b0};
            bit_d   = bit_q + 6'd1;
            if (bit_q == 6'd7) begin
              state_d = StAddr;
            end else if (bit_q == 6'd31) begin
              state_d = StData;
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StExec: begin
        csb_d  = 1'b1;
        sclk_d = 1'b0;
        io0_d  = 1'b0;
        case (rx_q[31:28])
          OP_HALT:   state_d = StHalt;
          OP_SET_IO: begin
            check_d = rx_q[15:0];
            state_d = StIdle;
          end
          OP_UART: begin
            uart_start = 1'b1;
            state_d    = StUart;
          end
          OP_WAIT: begin
            if (rx_q[23:0] == 24'd0) begin
              state_d = StIdle;
            end else begin
              wait_d  = rx_q[23:0];
              state_d = StWait;
            end
          end
          default: state_d = StIdle;
        endcase
      end
      StWait: begin
        wait_d = wait_q - 24'd1;
        if (wait_q == 24'd1) begin
          state_d = StIdle;
        end
      end
      StUart: begin
        if (!uart_busy) begin
          state_d = StIdle;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  boot_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clock(clock),
    .reset(reset),
    .start(uart_start),
    .data (rx_q[7:0]),
    .tx   (uart_tx),
    .busy (uart_busy)
  );

  always_comb begin
    mprj_io_out                   = '0;
    mprj_io_out[CHECK_LSB +: 16]  = check_q;
    mprj_io_out[UART_PAD]         = uart_tx;
    mprj_io_oeb                   = '1;
    mprj_io_oeb[CHECK_LSB +: 16]  = '0;
    mprj_io_oeb[UART_PAD]         = 1'b0;
  end

  assign flash_csb = csb_q;
  assign flash_clk = sclk_q;
  assign flash_io0 = io0_q;
  assign gpio      = (state_q == StHalt);

endmodule

// File: tb/tb_chaos_boot_harness.sv
// Directed bench for chaos_boot_harness with a behavioural SPI flash model.
module tb_chaos_boot_harness;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flash_csb, flash_clk, flash_io0, flash_io1;
  logic [37:0] mprj_io_in = '0;
  logic [37:0] mprj_io_out, mprj_io_oeb;
  logic        gpio;

  always #5 clock = ~clock;

  chaos_boot_harness #(
    .FLASH_DIV (1),
    .BAUD_DIV  (4),
    .START_ADDR(24'hFFFFFC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flash_csb  (flash_csb),
    .flash_clk  (flash_clk),
    .flash_io0  (flash_io0),
    .flash_io1  (flash_io1),
    .mprj_io_in (mprj_io_in),
    .mprj_io_out(mprj_io_out),
    .mprj_io_oeb(mprj_io_oeb),
    .gpio       (gpio)
  );

  int vectors = 0;
  int miscompares = 0;
  int t = 0;

  logic [31:0] mem [logic [23:0]];
  logic [23:0] txn_addr [$];
  logic [7:0]  txn_cmd [$];

  // Flash model: shifts MOSI on rising flash_clk, drives MISO after each falling edge.
  int          rise_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic [31:0] mosi_sh = '0;
  logic [31:0] cur_word = '0;
  logic [4:0]  bidx;

  always @(negedge clock) begin
    if (flash_csb) begin
      rise_cnt  = 0;
      prev_sclk = 1'b0;
      flash_io1 = 1'b0;
    end else begin
      if (flash_clk && !prev_sclk) begin
        rise_cnt++;
        if (rise_cnt <= 32) mosi_sh = {mosi_sh[30:0], flash_io0};
        if (rise_cnt == 32) begin
          txn_cmd.push_back(mosi_sh[31:24]);
          txn_addr.push_back(mosi_sh[23:0]);
          cur_word = mem.exists(mosi_sh[23:0]) ? mem[mosi_sh[23:0]] : 32'h0;
        end
      end else if (!flash_clk && prev_sclk) begin
        if (rise_cnt >= 32 && rise_cnt < 64) begin
          bidx      = 5'(63 - rise_cnt);
          flash_io1 = cur_word[bidx];
        end
      end
      prev_sclk = flash_clk;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    t++;
  endtask

  task automatic run_to(input int n);
    while (t < n) tick();
  endtask

  task automatic restart(input int hold);
    reset = 1'b1;
    repeat (hold) tick();
    txn_addr.delete();
    txn_cmd.delete();
    reset = 1'b0;
    t = 0;
  endtask

  logic [39:0] frame;

  initial begin
    flash_io1 = 1'b0;
    // Scenario A: SET_IO, NOP, SET_IO, SET_IO, HALT.
    mem[24'hFFFFFC] = 32'h1000AB40;
    mem[24'h000000] = 32'hF0000000;
    mem[24'h000004] = 32'h1000AB41;
    mem[24'h000008] = 32'h1000AB51;
    mem[24'h00000C] = 32'h00000000;
    repeat (100) tick();
    check("rst_csb", 64'(flash_csb), 64'd1);
    check("rst_sclk", 64'(flash_clk), 64'd0);
    check("rst_io0", 64'(flash_io0), 64'd0);
    check("rst_out", 64'(mprj_io_out), 64'h40);
    check("rst_oeb", 64'(mprj_io_oeb), 64'h3F0000FFBF);
    check("rst_gpio", 64'(gpio), 64'd0);
    reset = 1'b0;
    t = 0;
    tick();
    check("csb_t1", 64'(flash_csb), 64'd1);
    tick();
    check("csb_t2", 64'(flash_csb), 64'd0);
    run_to(129);
    check("chk_t129", 64'(mprj_io_out[31:16]), 64'h0);
    run_to(130);
    check("chk_t130", 64'(mprj_io_out[31:16]), 64'hAB40);
    check("csb_t130", 64'(flash_csb), 64'd1);
    check("txn0_cmd", 64'(txn_cmd[0]), 64'h03);
    check("txn0_addr", 64'(txn_addr[0]), 64'hFFFFFC);
    run_to(131);
    check("csb_gap", 64'(flash_csb), 64'd1);
    run_to(389);
    check("chk_t389", 64'(mprj_io_out[31:16]), 64'hAB40);
    run_to(390);
    check("chk_t390", 64'(mprj_io_out[31:16]), 64'hAB41);
    check("txn1_addr_wrap", 64'(txn_addr[1]), 64'h000000);
    check("txn2_addr", 64'(txn_addr[2]), 64'h000004);
    run_to(520);
    check("chk_t520", 64'(mprj_io_out[31:16]), 64'hAB51);
    run_to(649);
    check("gpio_t649", 64'(gpio), 64'd0);
    run_to(650);
    check("gpio_t650", 64'(gpio), 64'd1);
    begin
      int lows = 0;
      repeat (200) begin
        tick();
        if (!flash_csb) lows++;
      end
      check("halt_csb_lows", 64'(lows), 64'd0);
      check("halt_gpio", 64'(gpio), 64'd1);
      check("halt_txns", 64'(txn_addr.size()), 64'd5);
    end

    // Scenario B: UART byte 0x41 with BAUD_DIV=4, then HALT.
    mem.delete();
    mem[24'hFFFFFC] = 32'h20000041;
    mem[24'h000000] = 32'h00000000;
    restart(3);
    run_to(129);
    check("uart_idle", 64'(mprj_io_out[6]), 64'd1);
    for (int i = 0; i < 40; i++) begin
      run_to(130 + i);
      frame[39 - i] = mprj_io_out[6];
    end
    check("uart_frame", 64'(frame), 64'(40'b0000_1111_0000_0000_0000_0000_0000_1111_0000_1111));
    run_to(170);
    check("uart_after", 64'(mprj_io_out[6]), 64'd1);
    check("uart_chk", 64'(mprj_io_out[31:16]), 64'h0);
    run_to(300);
    check("uart_gpio_t300", 64'(gpio), 64'd0);
    run_to(301);
    check("uart_gpio_t301", 64'(gpio), 64'd1);

    // Scenario C: WAIT 16 between two SET_IO words; pad inputs toggled to all ones.
    mem.delete();
    mem[24'hFFFFFC] = 32'h1000AB40;
    mem[24'h000000] = 32'h30000010;
    mem[24'h000004] = 32'h1000AB41;
    mem[24'h000008] = 32'h00000000;
    mprj_io_in = '1;
    restart(2);
    run_to(130);
    check("wait_chk0", 64'(mprj_io_out[31:16]), 64'hAB40);
    run_to(405);
    check("wait_chk405", 64'(mprj_io_out[31:16]), 64'hAB40);
    run_to(406);
    check("wait_chk406", 64'(mprj_io_out[31:16]), 64'hAB41);
    check("wait_oeb", 64'(mprj_io_oeb), 64'h3F0000FFBF);
    mprj_io_in = '0;

    // Scenario D: reset during data bit 20 of the second transaction.
    mem.delete();
    mem[24'hFFFFFC] = 32'h1000AB40;
    mem[24'h000000] = 32'hF0000000;
    restart(2);
    run_to(237);
    check("mid_sclk", 64'(flash_clk), 64'd1);
    check("mid_csb", 64'(flash_csb), 64'd0);
    reset = 1'b1;
    tick();
    check("mid_rst_csb", 64'(flash_csb), 64'd1);
    check("mid_rst_sclk", 64'(flash_clk), 64'd0);
    check("mid_rst_out", 64'(mprj_io_out), 64'h40);
    txn_addr.delete();
    txn_cmd.delete();
    reset = 1'b0;
    t = 0;
    run_to(2);
    check("mid_restart_csb", 64'(flash_csb), 64'd0);
    run_to(130);
    check("mid_restart_addr", 64'(txn_addr[0]), 64'hFFFFFC);
    check("mid_restart_chk", 64'(mprj_io_out[31:16]), 64'hAB40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
